// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: sequencer state encodings and the stage-register
// hold/bubble control bundles driven by the hazard sequencer.
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] ST_WARMUP   = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MDU_WAIT = 2'd2;

    typedef enum logic [1:0] {
        WARMUP   = ST_WARMUP,
        RUN      = ST_RUN,
        MDU_WAIT = ST_MDU_WAIT
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic idex_hold;
        logic exmem_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
    localparam hz_ctrl_t CTRL_WARMUP = '{ifid_flush: 1'b1, idex_bubble: 1'b1,
                                         exmem_bubble: 1'b1, default: 1'b0};
    // Branch kills IF, ID and EX but keeps fetching from the new target.
    localparam hz_ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                         idex_bubble: 1'b1, exmem_bubble: 1'b1, default: 1'b0};
    localparam hz_ctrl_t CTRL_MDU_HOLD = '{idex_hold: 1'b1, exmem_bubble: 1'b1, default: 1'b0};
    localparam hz_ctrl_t CTRL_LOAD_USE = '{idex_bubble: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-sequencer signal bundle: pipeline status in, stage-register controls out.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  branch_taken;
    logic                  mdu_start;
    logic                  mdu_done;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  idex_bubble;
    logic                  idex_hold;
    logic                  exmem_bubble;
    logic                  mdu_error;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, mdu_start, mdu_done,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble,
               mdu_error, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, mdu_start, mdu_done,
        output pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble,
               mdu_error, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_compare.sv
// Load-use register-match comparator; register 0 never creates a dependency.
module hazard_compare #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    output logic                  load_use_o
);
    assign load_use_o = ex_mem_read_i && (ex_rt_i != '0) &&
                        ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer: warm-up bubbles, load-use stalls, branch flushes
// and MDU waits, with a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W    = 5,
    parameter int WARMUP_CYCLES = 4,
    parameter int MDU_TIMEOUT   = 64,
    parameter int CNT_W         = 16
) (
    input logic                   clock,
    input logic                   startin,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int WU_W  = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int MDU_W = $clog2(MDU_TIMEOUT);
    localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(WARMUP_CYCLES - 1);
    localparam logic [MDU_W-1:0] MDU_LAST = MDU_W'(MDU_TIMEOUT - 1);

    hz_state_e        state_q, state_d;
    logic [WU_W-1:0]  wu_cnt_q, wu_cnt_d;
    logic [MDU_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic             mdu_err_q, mdu_err_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    hz_ctrl_t         ctrl;
    logic             load_use;

    hazard_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp (
        .ex_mem_read_i (hz.ex_mem_read),
        .ex_rt_i       (hz.ex_rt),
        .id_rs_i       (hz.id_rs),
        .id_rt_i       (hz.id_rt),
        .id_uses_rt_i  (hz.id_uses_rt),
        .load_use_o    (load_use)
    );

    always_comb begin
        ctrl      = CTRL_WARMUP;
        state_d   = state_q;
        wu_cnt_d  = wu_cnt_q;
        mdu_cnt_d = mdu_cnt_q;
        mdu_err_d = mdu_err_q;
        case (state_q)
            WARMUP: begin
                ctrl = CTRL_WARMUP;
                if (wu_cnt_q == WU_LAST) state_d = RUN;
                else                     wu_cnt_d = wu_cnt_q + 1'b1;
            end
            RUN: begin
                if (hz.branch_taken) begin
                    ctrl = CTRL_BRANCH;
                end else if (hz.mdu_start) begin
                    ctrl      = CTRL_MDU_HOLD;
                    state_d   = MDU_WAIT;
                    mdu_cnt_d = '0;
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end else begin
                    ctrl = CTRL_RUN;
                end
            end
            MDU_WAIT: begin
                // Timeout releases exactly like a done, leaving only the sticky error.
                if (hz.mdu_done) begin
                    ctrl    = CTRL_RUN;
                    state_d = RUN;
                end else if (mdu_cnt_q == MDU_LAST) begin
                    ctrl      = CTRL_RUN;
                    state_d   = RUN;
                    mdu_err_d = 1'b1;
                end else begin
                    ctrl      = CTRL_MDU_HOLD;
                    mdu_cnt_d = mdu_cnt_q + 1'b1;
                end
            end
            default: begin
                ctrl    = CTRL_WARMUP;
                state_d = WARMUP;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if ((state_q != WARMUP) && !ctrl.pc_write && (stall_q != '1))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clock or posedge startin) begin
        if (startin) begin
            state_q   <= WARMUP;
            wu_cnt_q  <= '0;
            mdu_cnt_q <= '0;
            mdu_err_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wu_cnt_q  <= wu_cnt_d;
            mdu_cnt_q <= mdu_cnt_d;
            mdu_err_q <= mdu_err_d;
            stall_q   <= stall_d;
        end
    end

    assign hz.pc_write     = ctrl.pc_write;
    assign hz.ifid_write   = ctrl.ifid_write;
    assign hz.ifid_flush   = ctrl.ifid_flush;
    assign hz.idex_bubble  = ctrl.idex_bubble;
    assign hz.idex_hold    = ctrl.idex_hold;
    assign hz.exmem_bubble = ctrl.exmem_bubble;
    assign hz.mdu_error    = mdu_err_q;
    assign hz.stall_count  = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (WARMUP_CYCLES=4, MDU_TIMEOUT=8).
// Control vectors are {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble}.
module tb_pipeline_hazard_ctrl;
    localparam logic [5:0] C_RUN  = 6'b110000;
    localparam logic [5:0] C_WU   = 6'b001101;
    localparam logic [5:0] C_LU   = 6'b000100;
    localparam logic [5:0] C_BR   = 6'b111101;
    localparam logic [5:0] C_HOLD = 6'b000011;

    logic clock;
    logic startin;
    int   n_assert = 0;
    int   n_fail   = 0;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) hz ();

    pipeline_hazard_ctrl #(
        .REG_ADDR_W    (5),
        .WARMUP_CYCLES (4),
        .MDU_TIMEOUT   (8),
        .CNT_W         (16)
    ) dut (
        .clock   (clock),
        .startin (startin),
        .hz      (hz)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, hz.pc_write, hz.ifid_write, hz.ifid_flush,
                  hz.idex_bubble, hz.idex_hold, hz.exmem_bubble}, {26'd0, exp});
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 1'b0;
        hz.ex_mem_read = 1'b0; hz.ex_rt = '0;
        hz.branch_taken = 1'b0; hz.mdu_start = 1'b0; hz.mdu_done = 1'b0;
    endtask

    initial begin
        startin = 1'b1;
        clear_inputs();
        tick(); tick();
        #1;
        chk_ctrl("reset_ctrl", C_WU);
        chk("reset_stall", 32'(hz.stall_count), 32'd0);
        chk("reset_err", 32'(hz.mdu_error), 32'd0);

        // Warm-up with hazards presented: all ignored and not counted.
        startin = 1'b0;
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd3; hz.id_rs = 5'd3; hz.mdu_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_ctrl("warmup_ctrl", C_WU);
            if (i == 3) clear_inputs();
            tick();
        end
        #1;
        chk_ctrl("first_run", C_RUN);
        chk("first_run_stall", 32'(hz.stall_count), 32'd0);

        // Load-use on rs.
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd3; hz.id_rs = 5'd3;
        #1;
        chk_ctrl("lu_rs_ctrl", C_LU);
        tick(); clear_inputs(); #1;
        chk_ctrl("lu_rs_after", C_RUN);
        chk("lu_rs_stall", 32'(hz.stall_count), 32'd1);

        // Load to r0 never stalls.
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd0; hz.id_rs = 5'd0;
        #1;
        chk_ctrl("lu_r0_ctrl", C_RUN);
        tick(); clear_inputs(); #1;
        chk("lu_r0_stall", 32'(hz.stall_count), 32'd1);

        // rt match only matters when ID reads rt.
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd7; hz.id_rs = 5'd2; hz.id_rt = 5'd7;
        #1;
        chk_ctrl("lu_rt_unused", C_RUN);
        hz.id_uses_rt = 1'b1;
        #1;
        chk_ctrl("lu_rt_used", C_LU);
        tick(); clear_inputs(); #1;
        chk("lu_rt_stall", 32'(hz.stall_count), 32'd2);

        // Branch beats concurrent MDU start and load-use.
        hz.branch_taken = 1'b1; hz.mdu_start = 1'b1;
        hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd3; hz.id_rs = 5'd3;
        #1;
        chk_ctrl("branch_ctrl", C_BR);
        tick(); clear_inputs(); #1;
        chk_ctrl("branch_after", C_RUN);
        chk("branch_stall", 32'(hz.stall_count), 32'd2);

        // MDU with done in the 5th wait cycle; branch during wait is ignored.
        hz.mdu_start = 1'b1;
        #1;
        chk_ctrl("mdu_entry", C_HOLD);
        tick(); hz.mdu_start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            hz.branch_taken = (k == 2);
            #1;
            chk_ctrl("mdu_wait", C_HOLD);
            tick();
        end
        hz.branch_taken = 1'b0;
        hz.mdu_done = 1'b1;
        #1;
        chk_ctrl("mdu_done_ctrl", C_RUN);
        tick(); clear_inputs(); #1;
        chk_ctrl("mdu_after", C_RUN);
        chk("mdu_stall", 32'(hz.stall_count), 32'd7);
        chk("mdu_no_err", 32'(hz.mdu_error), 32'd0);

        // Timeout: entry + 7 holds, release on the 8th wait cycle.
        hz.mdu_start = 1'b1;
        #1;
        chk_ctrl("to_entry", C_HOLD);
        tick(); hz.mdu_start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            chk_ctrl("to_wait", C_HOLD);
            tick();
        end
        #1;
        chk_ctrl("to_release", C_RUN);
        chk("to_err_pre", 32'(hz.mdu_error), 32'd0);
        tick(); #1;
        chk_ctrl("to_after", C_RUN);
        chk("to_err", 32'(hz.mdu_error), 32'd1);
        chk("to_stall", 32'(hz.stall_count), 32'd15);
        tick(); #1;
        chk("to_err_sticky", 32'(hz.mdu_error), 32'd1);

        // MDU still usable after a timeout.
        hz.mdu_start = 1'b1;
        #1;
        chk_ctrl("mdu2_entry", C_HOLD);
        tick(); hz.mdu_start = 1'b0; hz.mdu_done = 1'b1;
        #1;
        chk_ctrl("mdu2_done", C_RUN);
        tick(); clear_inputs(); #1;
        chk_ctrl("mdu2_after", C_RUN);
        chk("mdu2_stall", 32'(hz.stall_count), 32'd16);
        chk("mdu2_err", 32'(hz.mdu_error), 32'd1);

        // Reset asserted in the middle of an MDU wait.
        hz.mdu_start = 1'b1;
        tick(); hz.mdu_start = 1'b0;
        tick(); #1;
        chk_ctrl("rst_mid_hold", C_HOLD);
        chk("rst_mid_stall_pre", 32'(hz.stall_count), 32'd18);
        startin = 1'b1;
        #1;
        chk_ctrl("rst_mid_ctrl", C_WU);
        chk("rst_mid_stall", 32'(hz.stall_count), 32'd0);
        chk("rst_mid_err", 32'(hz.mdu_error), 32'd0);
        tick(); startin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_ctrl("rewarm_ctrl", C_WU);
            tick();
        end
        #1;
        chk_ctrl("rerun", C_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
